// File: rtl/leaf_xbar_scheduler.sv
// leaf_xbar_scheduler: round-robin burst scheduler for the leaf router's single
// crossbar path. Picks one of five requesters (GPU, spine1..4), latches where the
// winner is going, paces beats against the destination's readiness, and aborts
// grants that sit stalled too long. Carries no data.
module leaf_xbar_scheduler #(
    parameter logic [3:0] GROUP_ID    = 4'b0100,
    parameter int         MAX_BURST   = 4,
    parameter int         STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arb_enable,
    input  logic [4:0]  req_valid,
    input  logic [29:0] req_dest,
    input  logic        gpu_out_ready,
    input  logic [3:0]  spine_out_ready,
    output logic [4:0]  req_ready,
    output logic [4:0]  grant,
    output logic [2:0]  current_grant,
    output logic [1:0]  direction,
    output logic [1:0]  spine_sel,
    output logic        busy,
    output logic        misroute,
    output logic        stall_abort
);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    // Where the granted requester's beats go; latched at grant time.
    typedef struct packed {
        logic       to_gpu;
        logic [1:0] spine;
    } target_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_LOOP = 2'b11;
    localparam logic [2:0] NO_GRANT = 3'b111;

    localparam logic [3:0] LAST_BEAT  = 4'(MAX_BURST - 1);
    localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

    state_t         state, state_nx;
    logic [2:0]     rr_ptr;
    logic [3:0]     beat_cnt;
    logic [7:0]     stall_cnt;
    target_t        tgt;

    logic [4:0][5:0] dest_arr;
    logic [5:0]      pick_dest;
    logic            pick_local;
    logic            pick_vld;
    logic [2:0]      pick;
    logic [3:0]      srch;

    logic target_ready, gv, fire, stalled, last_beat, abort;

    assign dest_arr   = req_dest;
    assign pick_dest  = dest_arr[pick];
    assign pick_local = (pick_dest[5:2] == GROUP_ID);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping mod 5.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 3'd0;
        srch     = 4'd0;
        for (int k = 0; k < 5; k++) begin
            srch = {1'b0, rr_ptr} + 4'(k);
            if (srch >= 4'd5) srch = srch - 4'd5;
            if (!pick_vld && req_valid[srch[2:0]]) begin
                pick_vld = 1'b1;
                pick     = srch[2:0];
            end
        end
    end

    // Beat handshake. grant is zero outside HOLD, so req_ready never depends on
    // req_valid; reset blocks a beat in the cycle it is asserted.
    assign target_ready = tgt.to_gpu ? gpu_out_ready : spine_out_ready[tgt.spine];
    assign gv           = |(req_valid & grant);
    assign req_ready    = (state == HOLD && target_ready && !reset) ? grant : 5'b0;
    assign fire         = gv && target_ready && (state == HOLD);
    assign stalled      = gv && !target_ready && (state == HOLD);
    assign last_beat    = fire && (beat_cnt == LAST_BEAT);
    assign abort        = stalled && (stall_cnt == STALL_LAST);
    assign stall_abort  = abort && !reset;
    assign busy         = (state == HOLD);

    // Next-state: grant from IDLE, leave HOLD on burst end / drop / watchdog.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_enable && pick_vld) state_nx = HOLD;
            HOLD:    if (last_beat || !gv || abort) state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, grant outputs, round-robin pointer and beat/stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= 3'd0;
            beat_cnt      <= 4'd0;
            stall_cnt     <= 8'd0;
            grant         <= 5'b0;
            current_grant <= NO_GRANT;
            direction     <= DIR_IDLE;
            spine_sel     <= 2'd0;
            misroute      <= 1'b0;
            tgt           <= '{to_gpu: 1'b1, spine: 2'd0};
        end else begin
            state    <= state_nx;
            misroute <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nx == HOLD) begin
                        grant         <= 5'b1 << pick;
                        current_grant <= pick;
                        beat_cnt      <= 4'd0;
                        stall_cnt     <= 8'd0;
                        if (pick == 3'd0) begin
                            if (pick_local) begin
                                direction <= DIR_LOOP;
                                spine_sel <= 2'd0;
                                tgt       <= '{to_gpu: 1'b1, spine: 2'd0};
                            end else begin
                                direction <= DIR_UP;
                                spine_sel <= pick_dest[1:0];
                                tgt       <= '{to_gpu: 1'b0, spine: pick_dest[1:0]};
                            end
                        end else begin
                            // Spines always deliver down to the GPU; a foreign
                            // group is flagged but not dropped.
                            direction <= DIR_DOWN;
                            spine_sel <= 2'd0;
                            tgt       <= '{to_gpu: 1'b1, spine: 2'd0};
                            misroute  <= !pick_local;
                        end
                    end
                end
                HOLD: begin
                    if (state_nx == GAP) begin
                        rr_ptr        <= (current_grant == 3'd4) ? 3'd0 : current_grant + 3'd1;
                        grant         <= 5'b0;
                        current_grant <= NO_GRANT;
                        direction     <= DIR_IDLE;
                        spine_sel     <= 2'd0;
                    end else if (fire) begin
                        beat_cnt  <= beat_cnt + 4'd1;
                        stall_cnt <= 8'd0;
                    end else if (stalled) begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                GAP: begin
                    beat_cnt  <= 4'd0;
                    stall_cnt <= 8'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_xbar_scheduler.sv
// Scoreboard bench for leaf_xbar_scheduler: stimulus pushes expected beats and
// pulses into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_leaf_xbar_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_enable;
    logic [4:0]  req_valid;
    logic [29:0] req_dest;
    logic        gpu_out_ready;
    logic [3:0]  spine_out_ready;
    logic [4:0]  req_ready;
    logic [4:0]  grant;
    logic [2:0]  current_grant;
    logic [1:0]  direction;
    logic [1:0]  spine_sel;
    logic        busy;
    logic        misroute;
    logic        stall_abort;

    leaf_xbar_scheduler dut (
        .clk(clk), .reset(reset), .arb_enable(arb_enable),
        .req_valid(req_valid), .req_dest(req_dest),
        .gpu_out_ready(gpu_out_ready), .spine_out_ready(spine_out_ready),
        .req_ready(req_ready), .grant(grant), .current_grant(current_grant),
        .direction(direction), .spine_sel(spine_sel), .busy(busy),
        .misroute(misroute), .stall_abort(stall_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [1:0] dir;
        logic [1:0] sel;
    } beat_t;

    beat_t exp_q[$];
    int    misr_q[$];
    int    abort_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    int         beats_left[5];
    logic [4:0] onebeat;
    logic [4:0] off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beats(input int idx, input logic [1:0] dir, input logic [1:0] sel, input int n);
        beat_t b;
        b.idx = idx; b.dir = dir; b.sel = sel;
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    task automatic set_valid();
        for (int i = 0; i < 5; i++) req_valid[i] = (beats_left[i] > 0) && !off[i];
    endtask

    task automatic set_dest(input int i, input logic [5:0] d);
        req_dest[6*i +: 6] = d;
    endtask

    // One clock: note which beats fire at the coming edge, then update the
    // requester model just after it.
    task automatic tick();
        logic [4:0] f;
        @(negedge clk);
        f = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (f[i]) begin
                if (beats_left[i] > 0) beats_left[i]--;
                off[i] = onebeat[i];
            end else begin
                off[i] = 1'b0;
            end
        end
        set_valid();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) beats_left[i] = 0;
        off = '0; onebeat = '0;
        set_valid();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every fired beat and every pulse must match the next expectation.
    always @(negedge clk) begin
        logic [4:0] f;
        beat_t      e;
        int         g;
        f = req_valid & req_ready;
        if (f != 5'b0) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL beat: unexpected beat fire=%b expected none", f);
            end else begin
                e = exp_q.pop_front();
                chk("beat{fire,dir,sel}", {f, direction, spine_sel}, {5'b1 << e.idx, e.dir, e.sel});
            end
        end
        if (misroute) begin
            if (misr_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL misroute: unexpected pulse grant=%0d expected none", current_grant);
            end else begin
                g = misr_q.pop_front();
                chk("misroute_grant", current_grant, g);
            end
        end
        if (stall_abort) begin
            if (abort_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL stall_abort: unexpected pulse grant=%0d expected none", current_grant);
            end else begin
                g = abort_q.pop_front();
                chk("stall_abort_grant", current_grant, g);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        arb_enable = 1'b1;
        req_dest = '0;
        gpu_out_ready = 1'b1;
        spine_out_ready = 4'hf;
        req_valid = '0;

        // Reset state (checked while reset is still held)
        reset = 1'b1;
        for (int i = 0; i < 5; i++) beats_left[i] = 0;
        off = '0; onebeat = '0;
        tick();
        chk("rst_req_ready", req_ready, 5'b0);
        chk("rst_grant", grant, 5'b0);
        chk("rst_current_grant", current_grant, 3'b111);
        chk("rst_direction", direction, 2'b00);
        chk("rst_spine_sel", spine_sel, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_misroute", misroute, 1'b0);
        chk("rst_stall_abort", stall_abort, 1'b0);
        tick();
        reset = 1'b0;

        // GPU loopback, 6 beats: 4-beat burst, GAP, IDLE, re-grant for 2
        set_dest(0, 6'b010010);
        push_beats(0, 2'b11, 2'd0, 6);
        beats_left[0] = 6; set_valid();
        tick();
        chk("t1_direction", direction, 2'b11);
        chk("t1_current_grant", current_grant, 3'd0);
        chk("t1_grant", grant, 5'b00001);
        chk("t1_req_ready", req_ready, 5'b00001);
        repeat (4) tick();
        chk("t1_beats_after_burst", beats_left[0], 2);
        chk("t1_gap_grant", grant, 5'b0);
        chk("t1_gap_current_grant", current_grant, 3'b111);
        chk("t1_gap_busy", busy, 1'b0);
        tick();
        chk("t1_idle_current_grant", current_grant, 3'b111);
        tick();
        chk("t1_regrant", current_grant, 3'd0);
        repeat (4) tick();
        chk("t1_done_beats", beats_left[0], 0);
        chk("t1_done_busy", busy, 1'b0);

        // GPU up to spine 3, paced by spine_out_ready[3]
        do_reset();
        set_dest(0, 6'b001011);
        spine_out_ready = 4'b0111;
        push_beats(0, 2'b01, 2'd3, 3);
        beats_left[0] = 3; set_valid();
        tick();
        chk("t2_direction", direction, 2'b01);
        chk("t2_spine_sel", spine_sel, 2'd3);
        chk("t2_ready_low", req_ready, 5'b0);
        set_dest(0, 6'b010000);
        tick();
        chk("t2_dest_latched", direction, 2'b01);
        chk("t2_stall_busy", busy, 1'b1);
        spine_out_ready[3] = 1'b1; #1;
        chk("t2_ready_follows_hi", req_ready, 5'b00001);
        tick();
        spine_out_ready[3] = 1'b0; #1;
        chk("t2_ready_follows_lo", req_ready, 5'b0);
        repeat (2) tick();
        chk("t2_pause_busy", busy, 1'b1);
        chk("t2_pause_beats", beats_left[0], 2);
        spine_out_ready[3] = 1'b1;
        repeat (4) tick();
        chk("t2_done_beats", beats_left[0], 0);
        chk("t2_done_busy", busy, 1'b0);

        // Spines 1, 3, 4 contending with one beat per grant
        do_reset();
        set_dest(1, 6'b010000); set_dest(3, 6'b010000); set_dest(4, 6'b010000);
        onebeat = 5'b11010;
        beats_left[1] = 100; beats_left[3] = 100; beats_left[4] = 100;
        push_beats(1, 2'b10, 2'd0, 1);
        push_beats(3, 2'b10, 2'd0, 1);
        push_beats(4, 2'b10, 2'd0, 1);
        push_beats(1, 2'b10, 2'd0, 1);
        set_valid();
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1)  chk("t3_grant1", current_grant, 3'd1);
            if (c == 3)  chk("t3_gap_current_grant", current_grant, 3'b111);
            if (c == 4)  chk("t3_idle_busy", busy, 1'b0);
            if (c == 5)  chk("t3_grant3", current_grant, 3'd3);
            if (c == 9)  chk("t3_grant4", current_grant, 3'd4);
            if (c == 13) chk("t3_grant1_again", current_grant, 3'd1);
        end
        for (int i = 0; i < 5; i++) beats_left[i] = 0;
        onebeat = '0; set_valid();
        repeat (2) tick();

        // Spine2 with foreign group: delivered down, misroute pulses once
        do_reset();
        set_dest(2, 6'b000100);
        push_beats(2, 2'b10, 2'd0, 2);
        misr_q.push_back(2);
        beats_left[2] = 2; set_valid();
        tick();
        chk("t4_direction", direction, 2'b10);
        chk("t4_misroute_pulse", misroute, 1'b1);
        tick();
        chk("t4_misroute_clear", misroute, 1'b0);
        repeat (3) tick();
        chk("t4_done_beats", beats_left[2], 0);

        // GPU to spine0 held not-ready: watchdog abort, rr_ptr moves to 1
        do_reset();
        set_dest(0, 6'b001000);
        set_dest(1, 6'b010000);
        spine_out_ready = 4'b1110;
        abort_q.push_back(0);
        beats_left[0] = 1; set_valid();
        tick();
        chk("t5_direction", direction, 2'b01);
        chk("t5_spine_sel", spine_sel, 2'd0);
        repeat (14) tick();
        chk("t5_no_abort_early", stall_abort, 1'b0);
        tick();
        chk("t5_abort_pulse", stall_abort, 1'b1);
        chk("t5_abort_busy", busy, 1'b1);
        tick();
        chk("t5_abort_cleared", stall_abort, 1'b0);
        chk("t5_gap_grant", grant, 5'b0);
        beats_left[1] = 1; set_valid();
        push_beats(1, 2'b10, 2'd0, 1);
        tick();
        tick();
        chk("t5_rr_advanced", current_grant, 3'd1);
        beats_left[0] = 0; set_valid();
        repeat (3) tick();
        spine_out_ready = 4'hf;

        // Reset on the second beat of a burst
        do_reset();
        set_dest(0, 6'b010010);
        push_beats(0, 2'b11, 2'd0, 1);
        beats_left[0] = 4; set_valid();
        tick();
        tick();
        reset = 1'b1; #1;
        chk("t6_ready_blocked", req_ready, 5'b0);
        tick();
        chk("t6_grant", grant, 5'b0);
        chk("t6_current_grant", current_grant, 3'b111);
        chk("t6_direction", direction, 2'b00);
        chk("t6_busy", busy, 1'b0);
        reset = 1'b0;
        beats_left[0] = 0; set_valid();
        tick();

        // arb_enable low holds off a pending request
        do_reset();
        arb_enable = 1'b0;
        set_dest(3, 6'b010001);
        push_beats(3, 2'b10, 2'd0, 1);
        beats_left[3] = 1; set_valid();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t7_no_grant", grant, 5'b0);
        end
        arb_enable = 1'b1;
        tick();
        chk("t7_grant", grant, 5'b01000);
        repeat (3) tick();

        repeat (3) tick();
        chk("end_beats_left", exp_q.size(), 0);
        chk("end_misroute_left", misr_q.size(), 0);
        chk("end_abort_left", abort_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
